// File: rtl/commit_sequencer.sv
// In-order retire sequencer: FIFO-buffered writeback, taken-jump flush/redirect, wrong-path drain.
// Define COMMIT_SEQ_PERF_EN to add stall/redirect/drop performance counters.
module commit_sequencer #(
  parameter int DEPTH     = 4,
  parameter int DRAIN_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [31:0] wb_inst,
  input  logic [63:0] wb_pc,
  input  logic        wb_jump_valid,
  input  logic [63:0] wb_jump_target,
  input  logic        wb_skip,
  output logic        wb_ready,
  output logic        commit_valid,
  output logic [31:0] commit_inst,
  output logic [63:0] commit_pc,
  output logic        commit_skip,
  input  logic        commit_ready,
  output logic [63:0] inst_counter,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        busy
`ifdef COMMIT_SEQ_PERF_EN
  ,
  output logic [63:0] perf_stall_cycles,
  output logic [63:0] perf_redirects,
  output logic [31:0] perf_drops
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DRAIN_MAX) + 1;

  typedef enum logic [1:0] {S_RUN, S_REDIRECT, S_DRAIN} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  drain_cnt_q, drain_cnt_d;
  logic [63:0]    inst_counter_q, inst_counter_d;
  logic [63:0]    redirect_pc_q, redirect_pc_d;

  logic [31:0]    inst_q [DEPTH];
  logic [31:0]    inst_d [DEPTH];
  logic [63:0]    pc_q   [DEPTH];
  logic [63:0]    pc_d   [DEPTH];
  logic [63:0]    jt_q   [DEPTH];
  logic [63:0]    jt_d   [DEPTH];
  logic           skip_q [DEPTH];
  logic           skip_d [DEPTH];
  logic           jv_q   [DEPTH];
  logic           jv_d   [DEPTH];

  logic           full, empty, ready_int, pop, push, taken, drain_match;
  logic [AW-1:0]  head, tail;
  logic [PW-1:0]  flushed;

`ifdef COMMIT_SEQ_PERF_EN
  logic [63:0] perf_stall_q, perf_stall_d;
  logic [63:0] perf_redir_q, perf_redir_d;
  logic [31:0] perf_drops_q, perf_drops_d;
`endif

  always_comb begin
    full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty       = (wr_ptr_q == rd_ptr_q);
    head        = rd_ptr_q[AW-1:0];
    tail        = wr_ptr_q[AW-1:0];
    flushed     = wr_ptr_q - rd_ptr_q - PW'(1);
    ready_int   = ((state_q == S_RUN) && !full) || (state_q == S_DRAIN);
    // Gated so every output reads 0 while reset is held.
    wb_ready    = ready_int && !rst;
    commit_valid = (state_q == S_RUN) && !empty;
    commit_inst = commit_valid ? inst_q[head] : 32'd0;
    commit_pc   = commit_valid ? pc_q[head]   : 64'd0;
    commit_skip = commit_valid ? skip_q[head] : 1'b0;
    pop         = commit_valid && commit_ready;
    taken       = pop && jv_q[head];
    drain_match = wb_valid && (wb_pc == redirect_pc_q);

    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    drain_cnt_d    = drain_cnt_q;
    redirect_pc_d  = redirect_pc_q;
    inst_counter_d = pop ? inst_counter_q + 64'd1 : inst_counter_q;
    inst_d         = inst_q;
    pc_d           = pc_q;
    jt_d           = jt_q;
    skip_d         = skip_q;
    jv_d           = jv_q;
    push           = 1'b0;
`ifdef COMMIT_SEQ_PERF_EN
    perf_stall_d = (commit_valid && !commit_ready) ? perf_stall_q + 64'd1 : perf_stall_q;
    perf_redir_d = perf_redir_q;
    perf_drops_d = perf_drops_q;
`endif

    case (state_q)
      S_RUN: begin
        if (taken) begin
          // Younger entries and any same-cycle push are wrong-path.
          rd_ptr_d      = wr_ptr_q;
          redirect_pc_d = jt_q[head];
          state_d       = S_REDIRECT;
`ifdef COMMIT_SEQ_PERF_EN
          perf_redir_d = perf_redir_q + 64'd1;
          perf_drops_d = perf_drops_q + 32'(flushed);
`endif
        end else begin
          push = wb_valid && ready_int;
          if (push) wr_ptr_d = wr_ptr_q + PW'(1);
          if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
      end
      S_REDIRECT: begin
        state_d     = S_DRAIN;
        drain_cnt_d = '0;
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + CW'(1);
        if (drain_match) begin
          push     = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          state_d  = S_RUN;
        end else begin
          if (drain_cnt_q == CW'(DRAIN_MAX - 1)) state_d = S_RUN;
`ifdef COMMIT_SEQ_PERF_EN
          if (wb_valid) perf_drops_d = perf_drops_d + 32'd1;
`endif
        end
      end
      default: state_d = S_RUN;
    endcase

    if (push) begin
      inst_d[tail] = wb_inst;
      pc_d[tail]   = wb_pc;
      jt_d[tail]   = wb_jump_target;
      skip_d[tail] = wb_skip;
      jv_d[tail]   = wb_jump_valid;
    end

    redirect_valid = (state_q == S_REDIRECT);
    redirect_pc    = redirect_pc_q;
    inst_counter   = inst_counter_q;
    busy           = !empty || (state_q != S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_RUN;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      drain_cnt_q    <= '0;
      inst_counter_q <= '0;
      redirect_pc_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
        jt_q[i]   <= '0;
        skip_q[i] <= 1'b0;
        jv_q[i]   <= 1'b0;
      end
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      drain_cnt_q    <= drain_cnt_d;
      inst_counter_q <= inst_counter_d;
      redirect_pc_q  <= redirect_pc_d;
      inst_q         <= inst_d;
      pc_q           <= pc_d;
      jt_q           <= jt_d;
      skip_q         <= skip_d;
      jv_q           <= jv_d;
    end
  end

`ifdef COMMIT_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_redir_q <= '0;
      perf_drops_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_redir_q <= perf_redir_d;
      perf_drops_q <= perf_drops_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_redirects    = perf_redir_q;
  assign perf_drops        = perf_drops_q;
`endif

endmodule

// File: tb/tb_commit_sequencer.sv
// Scoreboard bench for commit_sequencer: expected retires queued at push, checked at commit.
module tb_commit_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_inst = '0;
  logic [63:0] wb_pc = '0;
  logic        wb_jump_valid = 1'b0;
  logic [63:0] wb_jump_target = '0;
  logic        wb_skip = 1'b0;
  logic        wb_ready;
  logic        commit_valid;
  logic [31:0] commit_inst;
  logic [63:0] commit_pc;
  logic        commit_skip;
  logic        commit_ready = 1'b0;
  logic [63:0] inst_counter;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        busy;
`ifdef COMMIT_SEQ_PERF_EN
  logic [63:0] perf_stall_cycles;
  logic [63:0] perf_redirects;
  logic [31:0] perf_drops;
`endif

  commit_sequencer #(.DEPTH(4), .DRAIN_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_inst(wb_inst), .wb_pc(wb_pc),
    .wb_jump_valid(wb_jump_valid), .wb_jump_target(wb_jump_target),
    .wb_skip(wb_skip), .wb_ready(wb_ready),
    .commit_valid(commit_valid), .commit_inst(commit_inst), .commit_pc(commit_pc),
    .commit_skip(commit_skip), .commit_ready(commit_ready),
    .inst_counter(inst_counter), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy)
`ifdef COMMIT_SEQ_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles), .perf_redirects(perf_redirects),
    .perf_drops(perf_drops)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        skip;
    bit          lat;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          redir_cycles = 0;
  longint unsigned exp_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk_inst(input logic [63:0] pc);
    return pc[31:0] ^ 32'h0000_0013;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
      sb.delete();
    end else begin
      check_val("inst_counter", inst_counter, exp_cnt);
      if (redirect_valid) redir_cycles++;
      if (commit_valid && commit_ready) begin
        check_val("commit_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check_val("commit_pc", commit_pc, e.pc);
          check_val("commit_inst", 64'(commit_inst), 64'(e.inst));
          check_val("commit_skip", 64'(commit_skip), 64'(e.skip));
          if (e.lat) check_val("commit_latency", 64'(cyc), 64'(e.cyc + 1));
        end
        exp_cnt++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic do_push(input logic [63:0] pc, input logic jv, input logic [63:0] jt,
                         input bit retire, input bit lat, input int max_wait, output int waited);
    wb_valid       = 1'b1;
    wb_pc          = pc;
    wb_inst        = mk_inst(pc);
    wb_skip        = pc[2];
    wb_jump_valid  = jv;
    wb_jump_target = jt;
    waited = 0;
    forever begin
      @(negedge clk);
      if (wb_ready || waited >= max_wait) break;
      waited++;
      @(posedge clk); #1;
    end
    check_val("push_accept", 64'(wb_ready), 64'd1);
    if (retire) sb.push_back('{pc: pc, inst: mk_inst(pc), skip: pc[2], lat: lat, cyc: cyc});
    @(posedge clk); #1;
    wb_valid      = 1'b0;
    wb_jump_valid = 1'b0;
  endtask

  task automatic wait_sb_empty(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
    end
    check_val(tag, 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic jump_drain(input logic [63:0] jpc, input logic [63:0] tgt, input bit final_match);
    int w;
    commit_ready = 1'b1;
    redir_cycles = 0;
    do_push(jpc, 1'b1, tgt, 1'b1, 1'b1, 4, w);
    @(negedge clk);
    @(negedge clk);
    check_val("jd_redirect_valid", 64'(redirect_valid), 64'd1);
    check_val("jd_redirect_pc", redirect_pc, tgt);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      wb_valid = 1'b0;
      if (k <= 3) begin
        wb_valid = 1'b1;
        wb_pc    = tgt + 64'h40 + 64'(4 * k);
        wb_inst  = mk_inst(wb_pc);
      end else if (k == 16 && final_match) begin
        wb_valid = 1'b1;
        wb_pc    = tgt;
        wb_inst  = mk_inst(tgt);
        wb_skip  = tgt[2];
        sb.push_back('{pc: tgt, inst: mk_inst(tgt), skip: tgt[2], lat: 1'b1, cyc: cyc});
      end
      @(negedge clk);
      check_val("jd_drain_wb_ready", 64'(wb_ready), 64'd1);
      check_val("jd_drain_busy", 64'(busy), 64'd1);
      check_val("jd_drain_commit_valid", 64'(commit_valid), 64'd0);
    end
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(negedge clk);
    check_val("jd_back_in_run_ready", 64'(wb_ready), 64'd1);
    if (final_match) check_val("jd_final_match_commit", 64'(commit_valid), 64'd1);
    else             check_val("jd_timeout_idle", 64'(busy), 64'd0);
    check_val("jd_redirect_pulses", 64'(redir_cycles), 64'd1);
    @(posedge clk); #1;
    do_push(tgt + 64'h800, 1'b0, 64'd0, 1'b1, 1'b1, 2, w);
    check_val("jd_next_push_wait", 64'(w), 64'd0);
    wait_sb_empty("jd_sb_empty");
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_wb_ready", 64'(wb_ready), 64'd0);
    check_val("rst_commit_valid", 64'(commit_valid), 64'd0);
    check_val("rst_inst_counter", inst_counter, 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_redirect_pc", redirect_pc, 64'd0);
    rst = 1'b0;

    // In-order retire, one per cycle.
    commit_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_push(64'h8000_0000 + 64'(4 * i), 1'b0, 64'd0, 1'b1, 1'b1, 2, w);
      check_val("t1_wait", 64'(w), 64'd0);
    end
    wait_sb_empty("t1_sb_empty");
    check_val("t1_inst_counter", inst_counter, 64'd3);
    check_val("t1_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Backpressure: fill to DEPTH, no pop-bypass when full.
    commit_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_push(64'h8000_1000 + 64'(4 * i), 1'b0, 64'd0, 1'b1, 1'b0, 2, w);
      check_val("t2_wait", 64'(w), 64'd0);
    end
    wb_valid = 1'b1;
    wb_pc    = 64'h8000_1010;
    wb_inst  = mk_inst(wb_pc);
    @(negedge clk);
    check_val("t2_full_wb_ready", 64'(wb_ready), 64'd0);
    check_val("t2_full_commit_valid", 64'(commit_valid), 64'd1);
    @(posedge clk); #1;
    commit_ready = 1'b1;
    do_push(64'h8000_1010, 1'b0, 64'd0, 1'b1, 1'b0, 6, w);
    check_val("t2_no_bypass_wait", 64'(w), 64'd1);
    wait_sb_empty("t2_sb_empty");
    check_val("t2_inst_counter", inst_counter, 64'd8);
    @(posedge clk); #1;

    // Taken jump at head with two younger entries, then drain to target.
    commit_ready = 1'b0;
    redir_cycles = 0;
    do_push(64'h8000_0010, 1'b1, 64'h8000_0100, 1'b1, 1'b0, 2, w);
    do_push(64'h8000_0014, 1'b0, 64'd0, 1'b0, 1'b0, 2, w);
    do_push(64'h8000_0018, 1'b0, 64'd0, 1'b0, 1'b0, 2, w);
    commit_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("t3_redirect_valid", 64'(redirect_valid), 64'd1);
    check_val("t3_redirect_pc", redirect_pc, 64'h8000_0100);
    check_val("t3_redirect_wb_ready", 64'(wb_ready), 64'd0);
    check_val("t3_redirect_commit_valid", 64'(commit_valid), 64'd0);
    @(negedge clk);
    check_val("t3_drain_redirect_valid", 64'(redirect_valid), 64'd0);
    check_val("t3_flushed_commit_valid", 64'(commit_valid), 64'd0);
    check_val("t3_drain_wb_ready", 64'(wb_ready), 64'd1);
    @(posedge clk); #1;
    do_push(64'h8000_0014, 1'b0, 64'd0, 1'b0, 1'b0, 2, w);
    do_push(64'h8000_0018, 1'b0, 64'd0, 1'b0, 1'b0, 2, w);
    do_push(64'h8000_0100, 1'b0, 64'd0, 1'b1, 1'b1, 2, w);
    wait_sb_empty("t4_sb_empty");
    check_val("t4_inst_counter", inst_counter, 64'd10);
    check_val("t4_busy", 64'(busy), 64'd0);
    check_val("t4_redirect_pulses", 64'(redir_cycles), 64'd1);
    check_val("t4_redirect_pc_hold", redirect_pc, 64'h8000_0100);
    @(posedge clk); #1;

    // Drain timeout without a match, then a match on the final drain cycle.
    jump_drain(64'h8000_0200, 64'h8000_0300, 1'b0);
    jump_drain(64'h8000_0400, 64'h8000_0204, 1'b1);

    // Asynchronous reset with entries pending.
    commit_ready = 1'b0;
    do_push(64'h8000_2000, 1'b0, 64'd0, 1'b1, 1'b0, 2, w);
    do_push(64'h8000_2004, 1'b0, 64'd0, 1'b1, 1'b0, 2, w);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_val("ar_wb_ready", 64'(wb_ready), 64'd0);
    check_val("ar_commit_valid", 64'(commit_valid), 64'd0);
    check_val("ar_commit_pc", commit_pc, 64'd0);
    check_val("ar_commit_inst", 64'(commit_inst), 64'd0);
    check_val("ar_commit_skip", 64'(commit_skip), 64'd0);
    check_val("ar_inst_counter", inst_counter, 64'd0);
    check_val("ar_redirect_valid", 64'(redirect_valid), 64'd0);
    check_val("ar_redirect_pc", redirect_pc, 64'd0);
    check_val("ar_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    commit_ready = 1'b1;
    @(negedge clk);
    check_val("ar_post_busy", 64'(busy), 64'd0);
    check_val("ar_post_commit_valid", 64'(commit_valid), 64'd0);
    check_val("ar_post_wb_ready", 64'(wb_ready), 64'd1);
    @(posedge clk); #1;
    do_push(64'h8000_3000, 1'b0, 64'd0, 1'b1, 1'b1, 2, w);
    wait_sb_empty("ar_sb_empty");
    check_val("ar_post_inst_counter", inst_counter, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
